vga_pattern_gen: RTL and testbench

- Pixel-source stage directly downstream of vga_timing and upstream of the RGB output pins in vga_top.
- Consumes hcount/vcount/de/hsync/vsync and produces 3-3-3 RGB test patterns: colour bars, checkerboard, bouncing box and gradient.
- Delays the sync signals so they stay aligned with the pipelined RGB output.
- vga_top performs only the final sync polarity inversion.

---
 rtl/vga_pattern_gen_if.sv | 28 ++
 rtl/vga_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel-path bundle between vga_timing, vga_pattern_gen and the vga_top pins.
// The master drives timing inputs and mode requests. The slave returns pipelined RGB and sync signals.
interface vga_pattern_gen_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       de;
  logic       hsync_in;
  logic       vsync_in;
  logic       mode_next;
  logic [2:0] rgb_r;
  logic [2:0] rgb_g;
  logic [2:0] rgb_b;
  logic       hsync_out;
  logic       vsync_out;
  logic       de_out;
  logic       frame_tick;
  logic [1:0] mode;

  modport master (
    output hcount, vcount, de, hsync_in, vsync_in, mode_next,
    input  rgb_r, rgb_g, rgb_b, hsync_out, vsync_out, de_out, frame_tick, mode
  );

  modport slave (
    input  hcount, vcount, de, hsync_in, vsync_in, mode_next,
    output rgb_r, rgb_g, rgb_b, hsync_out, vsync_out, de_out, frame_tick, mode
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// 3-3-3 RGB test-pattern source with a fixed 2-cycle pipeline and matching sync delay.
// Define VGA_PATTERN_BORDER_EN to overlay a one-pixel red frame around the active area.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32
) (
  input logic               clk_pix,
  input logic               resetn,
  vga_pattern_gen_if.slave  vga
);

  typedef enum logic [1:0] {BARS = 2'd0, CHECKER = 2'd1, BOX = 2'd2, GRAD = 2'd3} mode_e;

  localparam int         BAR_W  = H_ACTIVE / 8;
  localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0] V_TICK = 10'(V_ACTIVE);

  // Returns {dir, pos}. dir=1 means moving toward the far edge.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] lim);
    if (dir && pos == lim)        return {1'b0, pos - 10'd1};
    if (!dir && pos == 10'd0)     return {1'b1, pos + 10'd1};
    return dir ? {1'b1, pos + 10'd1} : {1'b0, pos - 10'd1};
  endfunction

  logic       tick_cond;
  logic       mode_next_q;
  logic       rise;
  mode_e      mode_q, mode_d;
  logic       pending_q, pending_d;
  logic [9:0] box_x_q, box_y_q, box_x_d, box_y_d;
  logic       dir_x_q, dir_y_q, dir_x_d, dir_y_d;

  assign tick_cond = (vga.hcount == 10'd0) && (vga.vcount == V_TICK);
  assign rise      = vga.mode_next & ~mode_next_q;
  assign vga.mode  = mode_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q | rise;
    if (tick_cond && pending_d) begin
      pending_d = 1'b0;
      case (mode_q)
        BARS:    mode_d = CHECKER;
        CHECKER: mode_d = BOX;
        BOX:     mode_d = GRAD;
        default: mode_d = BARS;
      endcase
    end
  end

  always_comb begin
    {dir_x_d, box_x_d} = {dir_x_q, box_x_q};
    {dir_y_d, box_y_d} = {dir_y_q, box_y_q};
    if (tick_cond) begin
      {dir_x_d, box_x_d} = step_axis(box_x_q, dir_x_q, X_MAX);
      {dir_y_d, box_y_d} = step_axis(box_y_q, dir_y_q, Y_MAX);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      mode_q      <= BARS;
      pending_q   <= 1'b0;
      mode_next_q <= 1'b0;
      box_x_q     <= 10'd0;
      box_y_q     <= 10'd0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      mode_next_q <= vga.mode_next;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
    end
  end

  logic [2:0]  bar_k, bar_bits;
  logic        in_box;
  logic [2:0]  r_c, g_c, b_c;

  // Stage 1 colour. Bar index comes from threshold compares, so no divider is needed.
  always_comb begin
    bar_k = 3'd0;
    for (int i = 1; i < 8; i++)
      if (vga.hcount >= 10'(i * BAR_W)) bar_k = 3'(i);
    bar_bits = 3'd7 - bar_k;
    in_box = ({1'b0, vga.hcount} >= {1'b0, box_x_q}) &&
             ({1'b0, vga.hcount} <  {1'b0, box_x_q} + 11'(BOX_SIZE)) &&
             ({1'b0, vga.vcount} >= {1'b0, box_y_q}) &&
             ({1'b0, vga.vcount} <  {1'b0, box_y_q} + 11'(BOX_SIZE));
    r_c = 3'd0;
    g_c = 3'd0;
    b_c = 3'd0;
    case (mode_q)
      BARS: begin
        r_c = {3{bar_bits[2]}};
        g_c = {3{bar_bits[1]}};
        b_c = {3{bar_bits[0]}};
      end
      CHECKER: begin
        r_c = {3{vga.hcount[5] ^ vga.vcount[5]}};
        g_c = r_c;
        b_c = r_c;
      end
      BOX: begin
        r_c = in_box ? 3'd7 : 3'd0;
        g_c = in_box ? 3'd7 : 3'd0;
        b_c = in_box ? 3'd7 : 3'd2;
      end
      default: begin
        r_c = vga.hcount[8:6];
        g_c = vga.vcount[8:6];
        b_c = vga.hcount[8:6] ^ vga.vcount[8:6];
      end
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (vga.hcount == 10'd0 || vga.hcount == 10'(H_ACTIVE - 1) ||
        vga.vcount == 10'd0 || vga.vcount == 10'(V_ACTIVE - 1)) begin
      r_c = 3'd7;
      g_c = 3'd0;
      b_c = 3'd0;
    end
`else
`endif
  end

  logic [8:0] rgb_s1;
  logic       de_s1, hs_s1, vs_s1;

  // Data registers are reset too, so a mid-frame reset blanks the pins at once.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      rgb_s1         <= 9'd0;
      de_s1          <= 1'b0;
      hs_s1          <= 1'b0;
      vs_s1          <= 1'b0;
      vga.rgb_r      <= 3'd0;
      vga.rgb_g      <= 3'd0;
      vga.rgb_b      <= 3'd0;
      vga.de_out     <= 1'b0;
      vga.hsync_out  <= 1'b0;
      vga.vsync_out  <= 1'b0;
      vga.frame_tick <= 1'b0;
    end else begin
      rgb_s1         <= {r_c, g_c, b_c};
      de_s1          <= vga.de;
      hs_s1          <= vga.hsync_in;
      vs_s1          <= vga.vsync_in;
      vga.rgb_r      <= de_s1 ? rgb_s1[8:6] : 3'd0;
      vga.rgb_g      <= de_s1 ? rgb_s1[5:3] : 3'd0;
      vga.rgb_b      <= de_s1 ? rgb_s1[2:0] : 3'd0;
      vga.de_out     <= de_s1;
      vga.hsync_out  <= hs_s1;
      vga.vsync_out  <= vs_s1;
      vga.frame_tick <= tick_cond;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: patterns, pipeline alignment, mode FSM, box bounce, reset.
// Expected pixels account for the red border when VGA_PATTERN_BORDER_EN is defined.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_asserts = 0;
  int   n_fail = 0;
  int   ticks = 0;

  vga_pattern_gen_if bus ();

  vga_pattern_gen dut (
    .clk_pix (clk),
    .resetn  (resetn),
    .vga     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.hcount    = 10'd700;
    bus.vcount    = 10'd10;
    bus.de        = 1'b0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.mode_next = 1'b0;
  endtask

  function automatic logic [8:0] rgb_now();
    return {bus.rgb_r, bus.rgb_g, bus.rgb_b};
  endfunction

  // Present one active pixel and check the colour that emerges 2 cycles later.
  task automatic check_pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                           input logic [8:0] exp);
    logic [8:0] e;
    e = exp;
`ifdef VGA_PATTERN_BORDER_EN
    if (h == 10'd0 || h == 10'd639 || v == 10'd0 || v == 10'd479) e = 9'o700;
`else
`endif
    bus.hcount = h;
    bus.vcount = v;
    bus.de     = 1'b1;
    cyc();
    idle();
    cyc();
    check(tag, rgb_now(), e);
  endtask

  task automatic check_blank(input string tag, input logic [9:0] h, input logic [9:0] v);
    bus.hcount = h;
    bus.vcount = v;
    bus.de     = 1'b0;
    cyc();
    idle();
    cyc();
    check(tag, rgb_now(), 9'd0);
  endtask

  // One cycle at the first blank line start; optionally with a mode_next edge on the same cycle.
  task automatic frame(input logic pulse);
    bus.hcount    = 10'd0;
    bus.vcount    = 10'd480;
    bus.de        = 1'b0;
    bus.mode_next = pulse;
    cyc();
    ticks++;
    idle();
  endtask

  task automatic pulse_next();
    bus.mode_next = 1'b1;
    cyc();
    bus.mode_next = 1'b0;
    cyc();
  endtask

  initial begin
    logic [2:0] pat [6];
    pat = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b110, 3'b011};
    idle();

    // Reset state
    cyc();
    cyc();
    check("reset_rgb", rgb_now(), 9'd0);
    check("reset_sync", 9'({bus.de_out, bus.hsync_out, bus.vsync_out, bus.frame_tick}), 9'd0);
    check("reset_mode", 9'(bus.mode), 9'd0);
    resetn = 1'b1;
    cyc();

    // Colour bars
    check_pix("bars_h0",   10'd0,   10'd100, 9'o777);
    check_pix("bars_h79",  10'd79,  10'd100, 9'o777);
    check_pix("bars_h80",  10'd80,  10'd100, 9'o770);
    check_pix("bars_h559", 10'd559, 10'd100, 9'o007);
    check_pix("bars_h560", 10'd560, 10'd100, 9'o000);
    check_pix("bars_h639", 10'd639, 10'd100, 9'o000);
    check_blank("blank_bars", 10'd0, 10'd100);

    // de/hsync/vsync delayed by exactly 2
    for (int i = 0; i < 6; i++) begin
      bus.hcount   = 10'd200;
      bus.vcount   = 10'd200;
      bus.de       = pat[i][2];
      bus.hsync_in = pat[i][1];
      bus.vsync_in = pat[i][0];
      cyc();
      if (i >= 1) check("sync_delay", 9'({bus.de_out, bus.hsync_out, bus.vsync_out}), 9'(pat[i-1]));
    end
    idle();
    cyc();
    check("sync_delay_last", 9'({bus.de_out, bus.hsync_out, bus.vsync_out}), 9'(pat[5]));
    cyc();

    // Mode requests are held until the frame tick, and at most one advance is made.
    pulse_next();
    pulse_next();
    pulse_next();
    check("mode_hold", 9'(bus.mode), 9'd0);
    frame(1'b0);
    check("frame_tick_hi", 9'(bus.frame_tick), 9'd1);
    check("mode_adv1", 9'(bus.mode), 9'd1);
    cyc();
    check("frame_tick_lo", 9'(bus.frame_tick), 9'd0);
    frame(1'b0);
    check("mode_no_pending", 9'(bus.mode), 9'd1);
    cyc();

    check_pix("chk_96_0",  10'd96, 10'd0,  9'o777);
    check_pix("chk_32_32", 10'd32, 10'd32, 9'o000);
    check_pix("chk_0_0",   10'd0,  10'd0,  9'o000);

    frame(1'b1);
    check("mode_edge_on_tick", 9'(bus.mode), 9'd2);
    frame(1'b0);
    check("mode_after_edge_tick", 9'(bus.mode), 9'd2);
    cyc();

    // Box at (4,4) after 4 ticks
    check_pix("box_in_tl",   10'd4,  10'd4,  9'o777);
    check_pix("box_left",    10'd3,  10'd4,  9'o002);
    check_pix("box_in_r",    10'd35, 10'd4,  9'o777);
    check_pix("box_right",   10'd36, 10'd4,  9'o002);
    check_pix("box_in_b",    10'd10, 10'd35, 9'o777);
    check_pix("box_below",   10'd10, 10'd36, 9'o002);
    check_blank("blank_box", 10'd10, 10'd10);

    pulse_next();
    frame(1'b0);
    check("mode_grad", 9'(bus.mode), 9'd3);
    cyc();
    check_pix("grad_a", 10'd448, 10'd192, 9'o734);
    check_pix("grad_b", 10'd64,  10'd448, 9'o176);
    check_blank("blank_grad", 10'd448, 10'd192);
    pulse_next();
    frame(1'b0);
    check("mode_wrap", 9'(bus.mode), 9'd0);
    cyc();

    // Back to BOX mode, then let the box travel
    pulse_next();
    frame(1'b0);
    pulse_next();
    frame(1'b0);
    check("mode_box_again", 9'(bus.mode), 9'd2);
    while (ticks < 448) frame(1'b0);
    cyc();
    check_pix("y448_in",  10'd460, 10'd448, 9'o777);
    check_pix("y448_out", 10'd460, 10'd447, 9'o002);
    frame(1'b0);
    cyc();
    check_pix("y447_in",  10'd460, 10'd447, 9'o777);
    check_pix("y447_out", 10'd460, 10'd479, 9'o002);
    while (ticks < 608) frame(1'b0);
    cyc();
    check_pix("x608_in",   10'd608, 10'd300, 9'o777);
    check_pix("x608_out",  10'd607, 10'd300, 9'o002);
    check_pix("x608_edge", 10'd639, 10'd300, 9'o777);
    frame(1'b0);
    cyc();
    check_pix("x607_in",   10'd607, 10'd300, 9'o777);
    check_pix("x607_edge", 10'd639, 10'd300, 9'o002);

    // Asynchronous reset mid-line in BOX mode
    bus.hcount   = 10'd300;
    bus.vcount   = 10'd300;
    bus.de       = 1'b1;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    cyc();
    cyc();
    check("pre_reset_rgb", rgb_now(), 9'o002);
    #3;
    resetn = 1'b0;
    #1;
    check("mid_reset_rgb", rgb_now(), 9'd0);
    check("mid_reset_sync", 9'({bus.de_out, bus.hsync_out, bus.vsync_out, bus.frame_tick}), 9'd0);
    check("mid_reset_mode", 9'(bus.mode), 9'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    check("post_reset_lat1", 9'(bus.de_out), 9'd0);
    cyc();
    check("post_reset_lat2", 9'({bus.de_out, bus.hsync_out, bus.vsync_out}), 9'b111);
    check("post_reset_rgb", rgb_now(), 9'o700);
    idle();
    cyc();

    // Box restarts from the origin: (2,2) after two ticks
    pulse_next();
    frame(1'b0);
    pulse_next();
    frame(1'b0);
    cyc();
    check_pix("box_origin_in",  10'd2, 10'd2, 9'o777);
    check_pix("box_origin_out", 10'd1, 10'd2, 9'o002);

    // Border case: red when the border is enabled, bar 0 white otherwise
    pulse_next();
    frame(1'b0);
    pulse_next();
    frame(1'b0);
    cyc();
    check("mode_bars_end", 9'(bus.mode), 9'd0);
    check_pix("border_h0_v100", 10'd0, 10'd100, 9'o777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
